// File: rtl/bus_master_6502_if.sv
// Command/response handshake between a sequencer and the 6502-side bus master.
// The sequencer uses the master modport; bus_master_6502 uses the slave modport.
interface bus_master_6502_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bus_master_6502.sv
// Bus initiator that drives the CPU side of the 6502 memory bus from a command stream.
// Define BUS_MASTER_TRACE_EN for a simulation-only per-transaction trace line.
//
// state | meaning
// IDLE  | clk held low, cmd_ready high, waiting for a command
// SETUP | address/direction driven, clk low for HALF cycles
// HIGH  | clk high for HALF cycles, read data captured as clk falls
// HOLD  | one cycle after the falling edge so memory commits with a, rw, dout still valid
module bus_master_6502 #(
    parameter int unsigned HALF = 2
) (
    input  logic                eclk,
    input  logic                ereset,
    bus_master_6502_if.slave    cmd,
    output logic                clk,
    output logic [15:0]         a,
    output logic [7:0]          dout,
    input  logic [7:0]          din,
    output logic                rw
);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(HALF - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        clk_nxt;
    logic [15:0] a_nxt;
    logic [7:0]  dout_nxt;
    logic        rw_nxt;
    logic        rsp_valid_q, rsp_valid_nxt;
    logic [7:0]  rsp_rdata_q, rsp_rdata_nxt;
    logic        accept;

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_rdata = rsp_rdata_q;
    assign accept        = cmd.cmd_valid && (state == IDLE);

    always_ff @(posedge eclk) begin
        if (ereset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            clk         <= 1'b0;
            a           <= 16'd0;
            dout        <= 8'd0;
            rw          <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            clk         <= clk_nxt;
            a           <= a_nxt;
            dout        <= dout_nxt;
            rw          <= rw_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        clk_nxt       = clk;
        a_nxt         = a;
        dout_nxt      = dout;
        rw_nxt        = rw;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_q;
        case (state)
            IDLE: begin
                clk_nxt = 1'b0;
                if (accept) begin
                    a_nxt     = cmd.cmd_addr;
                    rw_nxt    = cmd.cmd_rw;
                    if (!cmd.cmd_rw) dout_nxt = cmd.cmd_wdata;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    clk_nxt   = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = HIGH;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HIGH: begin
                if (cnt == 8'd0) begin
                    clk_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    if (rw) rsp_rdata_nxt = din;
                    state_nxt     = HOLD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                // Parking rw high means any later clk glitch can only look like a read.
                rw_nxt    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BUS_MASTER_TRACE_EN
`ifndef SYNTHESIS
    always_ff @(posedge eclk) begin
        if (!ereset && state == HOLD) begin
            if (rw) $display("%0t R %h -> %h", $time, a, rsp_rdata_q);
            else    $display("%0t W %h <- %h", $time, a, dout);
        end
    end
`endif
`else
    // Trace disabled: no simulation output, identical cycle behaviour.
`endif

endmodule
